// File: rtl/csr_irq_file.sv
// Machine-mode CSR file: mstatus, mie, mtvec, mepc, mcause, mip and a 64-bit cycle counter.
// Level-sensitive interrupt lines are registered and arbitrated lowest-index-first.
module csr_irq_file #(
    parameter int N_IRQ       = 4,
    parameter bit VECTORED_EN = 1'b1,
    parameter bit CYCLE_EN    = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [11:0]      ADDR,
    input  logic [31:0]      WD,
    input  logic [1:0]       OP,
    output logic [31:0]      RD,
    input  logic [31:0]      PC,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic             INT_TAKEN,
    input  logic             MRET,
    output logic             INT_REQ,
    output logic [31:0]      TRAP_PC,
    output logic [31:0]      CSR_MEPC
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] mie_r;
    logic [N_IRQ-1:0] active;
    logic             mstatus_mie;
    logic             mstatus_mpie;
    logic [29:0]      mtvec_base;
    logic             mtvec_mode;
    logic [31:0]      mepc_r;
    logic [31:0]      mcause_r;
    logic [63:0]      cycle_r;

    logic [3:0]  winner;
    logic        trap_fire;
    logic        csr_en;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic [31:0] mie_word;
    logic [31:0] mip_word;
    logic [31:0] trap_offset;

    always_comb begin
        mie_word = '0;
        mie_word[16 +: N_IRQ] = mie_r;
        mip_word = '0;
        mip_word[16 +: N_IRQ] = pend;
    end

    always_comb begin
        case (ADDR)
            ADDR_MSTATUS: old_val = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
            ADDR_MIE:     old_val = mie_word;
            ADDR_MTVEC:   old_val = {mtvec_base, 1'b0, mtvec_mode};
            ADDR_MEPC:    old_val = mepc_r;
            ADDR_MCAUSE:  old_val = mcause_r;
            ADDR_MIP:     old_val = mip_word;
            ADDR_MCYCLE:  old_val = cycle_r[31:0];
            ADDR_MCYCLEH: old_val = cycle_r[63:32];
            default:      old_val = '0;
        endcase
    end

    always_comb begin
        case (OP)
            OP_WRITE: new_val = WD;
            OP_SET:   new_val = old_val | WD;
            OP_CLEAR: new_val = old_val & ~WD;
            default:  new_val = old_val;
        endcase
    end

    assign active = pend & mie_r;

    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) winner = 4'(i);
        end
    end

    assign INT_REQ   = mstatus_mie & (|active);
    assign trap_fire = INT_TAKEN & INT_REQ;
    // A committed trap swallows the CSR op of the same cycle.
    assign csr_en    = (OP != OP_NONE) && !trap_fire;

    // Vector offset is 4*(16+winner); 16+winner is just winner with bit 4 set.
    assign trap_offset = mtvec_mode ? {25'd0, 1'b1, winner, 2'b00} : 32'd0;
    assign TRAP_PC     = {mtvec_base, 2'b00} + trap_offset;
    assign RD          = old_val;
    assign CSR_MEPC    = mepc_r;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend         <= '0;
            mie_r        <= '0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec_base   <= '0;
            mtvec_mode   <= 1'b0;
            mepc_r       <= '0;
            mcause_r     <= '0;
        end else begin
            pend <= IRQ;
            if (trap_fire) begin
                mepc_r       <= PC & 32'hFFFF_FFFC;
                mcause_r     <= {1'b1, 26'd0, 1'b1, winner};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (MRET) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (csr_en && ADDR == ADDR_MSTATUS) begin
                mstatus_mie  <= new_val[3];
                mstatus_mpie <= new_val[7];
            end

            if (csr_en) begin
                case (ADDR)
                    ADDR_MIE: mie_r <= new_val[16 +: N_IRQ];
                    ADDR_MTVEC: begin
                        mtvec_base <= new_val[31:2];
                        mtvec_mode <= VECTORED_EN ? new_val[0] : 1'b0;
                    end
                    ADDR_MEPC:   mepc_r   <= new_val & 32'hFFFF_FFFC;
                    ADDR_MCAUSE: mcause_r <= new_val;
                    default: ;
                endcase
            end
        end
    end

    // Writing one half of the counter suppresses the carry between halves that cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cycle_r <= '0;
        end else if (CYCLE_EN) begin
            if (csr_en && ADDR == ADDR_MCYCLE) begin
                cycle_r[31:0] <= new_val;
            end else if (csr_en && ADDR == ADDR_MCYCLEH) begin
                cycle_r[63:32] <= new_val;
                cycle_r[31:0]  <= cycle_r[31:0] + 32'd1;
            end else begin
                cycle_r <= cycle_r + 64'd1;
            end
        end
    end

endmodule

// File: doc/csr_irq_file.md
# csr_irq_file

Machine-mode CSR file with multi-channel interrupt support for the RISC-V core. Holds mstatus, mie, mtvec (direct or vectored), mepc, mcause, mip and a 64-bit cycle counter. Arbitrates N_IRQ level-sensitive interrupt lines and presents a trap request and target PC to the control unit. Handles trap entry and MRET state updates.

## Interface
- N_IRQ, 4: interrupt channels, 1..16; channel i maps to cause/mie/mip bit 16+i
- VECTORED_EN, 1: 1 allows mtvec.MODE=1 (vectored); 0 forces MODE bits to 0
- CYCLE_EN, 1: 1 implements mcycle/mcycleh; 0 reads them as 0 and ignores writes

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ADDR  in  12  CSR address
- WD  in  32  CSR operand
- OP  in  2  00 none, 01 write, 10 set (old|WD), 11 clear (old&~WD)
- RD  out  32  combinational read of the current value at ADDR (pre-update)
- PC  in  32  PC of the instruction being interrupted
- IRQ  in  N_IRQ  level-sensitive interrupt lines
- INT_TAKEN  in  1  control commits a trap this cycle
- MRET  in  1  MRET retires this cycle
- INT_REQ  out  1  interrupt pending and enabled
- TRAP_PC  out  32  handler address for the current winning channel
- CSR_MEPC  out  32  mepc contents (MRET target)

## Operation
- Map: mstatus 0x300 (MIE bit 3, MPIE bit 7; other bits read 0); mie 0x304 (bits 16+i); mtvec 0x305 (BASE [31:2], MODE [1:0], only bit 0 writable); mepc 0x341 (bits [1:0] read 0); mcause 0x342; mip 0x344 (read-only); mcycle 0xB00; mcycleh 0xB80.
- Unmapped address: RD=0 and writes are ignored. Unimplemented bits read 0.
- pend register: IRQ is registered every cycle. mip bit 16+i = pend[i]. pend is not cleared by a trap; the source must deassert.
- active = pend & mie[16+N_IRQ-1:16]. The winner is the lowest-index set bit of active.
- INT_REQ = mstatus.MIE & |active.
- TRAP_PC = {BASE,2'b00} when MODE=0. When MODE=1, TRAP_PC = {BASE,2'b00} + 4*(16+winner). It is computed combinationally from the current state.
- INT_TAKEN with INT_REQ=1 performs these updates:
  - mepc <= {PC[31:2],2'b00}
  - mcause <= {1'b1, 31'(16+winner)}
  - MPIE <= MIE
  - MIE <= 0
- INT_TAKEN with INT_REQ=0 is ignored.
- MRET: MIE <= MPIE; MPIE <= 1.
- Cycle counter: a 64-bit counter increments by 1 every cycle.
  - A write/set/clear to mcycle replaces the low word. There is no increment that cycle, and no carry that cycle.
  - A write to mcycleh replaces the high word. The low word still increments; any carry is lost that cycle.
- Priority within one cycle:
  - A valid INT_TAKEN beats MRET. MRET is dropped.
  - A valid INT_TAKEN also suppresses the CSR op entirely.
  - MRET beats a CSR op targeting mstatus. CSR ops to other addresses still apply.

## Timing
- All registers reset asynchronously to 0: pend, mstatus, mie, mtvec, mepc, mcause and the counter. Therefore INT_REQ=0, CSR_MEPC=0 and TRAP_PC=0 from reset.
- CSR op: the result is visible on RD and the outputs the next cycle.
- IRQ rising -> mip/INT_REQ high 1 cycle later, given enables are set. IRQ falling -> low 1 cycle later.
- Trap entry: INT_REQ drops the cycle after INT_TAKEN, because MIE is cleared.
- RST asserted mid-operation clears state immediately, independent of CLK.
- Counter wrap: 0xFFFFFFFF_FFFFFFFF -> 0.

## Test plan
- Reset with RST mid-cycle -> all CSR reads 0, INT_REQ=0, TRAP_PC=0. After release, mcycle reads 1, 2, 3 on consecutive cycles.
- Write mtvec=0x0000_1001, mie=0x0003_0000, mstatus=0x8. Drive IRQ=4'b0011 -> INT_REQ=1 one cycle later and TRAP_PC=0x1040. Pulse INT_TAKEN with PC=0x200 ->
  - mepc=0x200
  - mcause=0x8000_0010
  - mstatus=0x80
  - INT_REQ=0
- Then MRET -> mstatus=0x88. INT_REQ returns to 1 while IRQ stays high.
- VECTORED_EN=0: write mtvec=0x1001 -> reads 0x1000 and TRAP_PC=0x1000 for every channel.
- Set/clear: mie set 0x000F_0000, then clear 0x0005_0000 -> 0x000A_0000. A write to mip of 0xFFFF_FFFF is ignored.
- Same-cycle collisions:
  - INT_TAKEN + MRET + write mtvec -> only the trap updates occur; mtvec is unchanged.
  - MRET + write mstatus=0 -> MRET result wins.
- Counter: write mcycleh=0, mcycle=0xFFFF_FFFE -> after 2 cycles, mcycleh=1 and mcycle=0.
